// File: rtl/flag_register_unit.sv
// flag_register_unit
// Two-stage condition-flag register: the ALU flags are captured into a
// pending register on a flag-update request and committed to the
// architectural flag register on the following edge. The committed carry
// is fed back to the ALU. Optional build macro FLAG_FWD_EN forwards pending
// flags to the condition tester instead of stalling the control unit.
module flag_register_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] alu_flags,
  input  logic       s_en,
  input  logic       hold,
  input  logic       flags_req,
  output logic       N,
  output logic       Z,
  output logic       C,
  output logic       V,
  output logic       cin,
  output logic       stall,
  output logic [7:0] upd_cnt
);

  // Bit positions inside a {N,Z,C,V} flag vector
  localparam int unsigned BIT_N = 3;
  localparam int unsigned BIT_Z = 2;
  localparam int unsigned BIT_C = 1;
  localparam int unsigned BIT_V = 0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t     state_r;
  logic [3:0] pend_reg_r;
  logic [3:0] flag_reg_r;
  logic [7:0] upd_cnt_r;

  logic       capture_s;
  logic [3:0] flags_out_s;
  logic       stall_s;

  // A capture needs a request and no freeze; a frozen request is dropped
  always_comb begin
    capture_s = 1'b0;
    if (s_en && !hold) begin
      capture_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
  end

  // Capture/commit pipeline: commit whatever is pending, then optionally capture new flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      pend_reg_r <= 4'b0000;
      flag_reg_r <= 4'b0000;
      upd_cnt_r  <= 8'd0;
    end else begin
      // The commit is unconditional in PEND; hold only blocks new captures
      if (state_r == PEND) begin
        flag_reg_r <= pend_reg_r;
        upd_cnt_r  <= upd_cnt_r + 8'd1;
      end else begin
        flag_reg_r <= flag_reg_r;
        upd_cnt_r  <= upd_cnt_r;
      end

      if (capture_s) begin
        pend_reg_r <= alu_flags;
        state_r    <= PEND;
      end else begin
        pend_reg_r <= pend_reg_r;
        state_r    <= IDLE;
      end
    end
  end

  // Flag view for the condition tester and the stall request to the control unit
  always_comb begin
    flags_out_s = flag_reg_r;
    stall_s     = 1'b0;
    case (state_r)
      IDLE: begin
        flags_out_s = flag_reg_r;
        stall_s     = 1'b0;
      end
      PEND: begin
`ifdef FLAG_FWD_EN
        // Pending flags are forwarded, so the control unit never waits
        flags_out_s = pend_reg_r;
        stall_s     = 1'b0;
`else
        // Committed flags are stale while an update is pending
        flags_out_s = flag_reg_r;
        stall_s     = flags_req;
`endif
      end
      default: begin
        flags_out_s = flag_reg_r;
        stall_s     = 1'b0;
      end
    endcase
  end

  assign N       = flags_out_s[BIT_N];
  assign Z       = flags_out_s[BIT_Z];
  assign C       = flags_out_s[BIT_C];
  assign V       = flags_out_s[BIT_V];
  // Carry-in always comes from the committed flags, never the pending ones
  assign cin     = flag_reg_r[BIT_C];
  assign stall   = stall_s;
  assign upd_cnt = upd_cnt_r;

endmodule

// File: doc/flag_register_unit.md
FLAG_REGISTER_UNIT -- requirements
Module: flag_register_unit

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The module SHALL have port alu_flags, input, 4 bits: {N,Z,C,V} produced by the ALU, bit 3 = N, bit 0 = V.
REQ-004 The module SHALL have port s_en, input, 1 bit: flag-update request (S bit set on the executing instruction).
REQ-005 The module SHALL have port hold, input, 1 bit: pipeline freeze from the control unit.
REQ-006 The module SHALL have port flags_req, input, 1 bit: the control unit evaluates a condition code this cycle.
REQ-007 The module SHALL have ports N, Z, C, V, each output, 1 bit: flags presented to the condition tester.
REQ-008 The module SHALL have port cin, output, 1 bit: committed carry fed back to the ALU carry-in.
REQ-009 The module SHALL have port stall, output, 1 bit: flags not yet usable and the control unit must wait.
REQ-010 The module SHALL have port upd_cnt, output, 8 bits: count of committed flag updates.

Function
REQ-011 The module SHALL hold state IDLE (no pending update) or PEND (pend_reg holds uncommitted flags).
REQ-012 At a rising edge with s_en=1 and hold=0, the module SHALL load pend_reg with alu_flags and enter PEND.
REQ-013 At any rising edge in PEND, the module SHALL copy pend_reg into flag_reg (commit) and increment upd_cnt, regardless of hold.
REQ-014 For a commit and a new capture at the same edge, the module SHALL commit the old pend_reg, load the new alu_flags into pend_reg, and remain in PEND.
REQ-015 In PEND with no new capture at an edge, the module SHALL return to IDLE after committing.
REQ-016 With s_en=1 and hold=1 together, the module SHALL let hold win: no capture, and the request is dropped, not queued.
REQ-017 Latency: for s_en sampled at edge k, the module SHALL have pend_reg valid after edge k and flag_reg updated after edge k+1.
REQ-018 The module SHALL drive cin from flag_reg[C] only, never from pend_reg.
REQ-019 The module SHALL wrap upd_cnt from 255 to 0 without saturating.
REQ-020 In IDLE, the module SHALL drive N, Z, C and V from flag_reg, and SHALL keep stall=0.
REQ-021 The module SHALL generate stall combinationally from state and flags_req, with no extra register.

Reset
REQ-022 While reset=1, the module SHALL immediately clear flag_reg to 0000, pend_reg to 0000, upd_cnt to 0 and state to IDLE, independent of clk.
REQ-023 While reset=1, the module SHALL drive N=Z=C=V=0, cin=0 and stall=0.
REQ-024 A reset asserted in PEND SHALL discard the pending update: no commit, and no upd_cnt increment.
REQ-025 On the first rising edge after reset deasserts, the module SHALL honour s_en normally.

Configuration
REQ-026 With macro FLAG_FWD_EN defined, in PEND the module SHALL drive N, Z, C and V from pend_reg (forwarding), and stall SHALL stay 0.
REQ-027 With FLAG_FWD_EN undefined, in PEND the module SHALL drive N, Z, C and V from flag_reg, and SHALL set stall = flags_req.
REQ-028 All other behaviour, including cin, commit timing and upd_cnt, SHALL be identical in both builds.

Verification
REQ-029 Bench SHALL check: reset, then alu_flags=0100, s_en=1 for one cycle -> pend=0100 after edge 1; flag_reg=0100, Z=1, upd_cnt=1 after edge 2.
REQ-030 Bench SHALL check, with FWD on: capture alu_flags=1010, flags_req=1 in PEND -> N=1, V=0 (forwarded), stall=0, cin=old C.
REQ-031 Bench SHALL check, with FWD off, same stimulus as REQ-030 -> stall=1 for one cycle, N/Z/C/V = old flag_reg, then stall=0 and N=1 next cycle.
REQ-032 Bench SHALL check back-to-back s_en with alu_flags 0010 then 0001 -> flag_reg 0010 then 0001 on successive edges, upd_cnt +2, state PEND then IDLE.
REQ-033 Bench SHALL check s_en=1 with hold=1 -> no capture and upd_cnt unchanged, while a pending update still commits.
REQ-034 Bench SHALL check reset pulsed mid-clock while in PEND -> outputs 0 immediately; then 256 commits -> upd_cnt wraps to 0.
